ck_freq_mon: RTL and testbench

- Frequency monitor: the checking end of the clock synthesizer path.
- Counts rising edges of an externally generated clock-derived signal (e.g. the synthesized clock divided down) over a fixed gate window of ck_in cycles.
- Reports the count per window, flags whether it lies in an expected band, and asserts locked after consecutive good windows.
- Sits in the ck_in domain, feeding status/debug logic and reset sequencing.

---
 rtl/ck_freq_mon.sv | 147 ++++++++++++++
 tb/tb_ck_freq_mon.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ck_freq_mon.sv
// Frequency monitor: counts sig_in rising edges over a fixed ck_in gate
// window, checks the count against a band and tracks lock.
module ck_freq_mon #(
    parameter int GATE_CYCLES  = 1024,
    parameter int CNT_W        = 16,
    parameter int EXP_MIN      = 0,
    parameter int EXP_MAX      = 65535,
    parameter int LOCK_WINDOWS = 4
) (
    input  logic             ck_in,
    input  logic             sys_rst_i,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             overflow,
    output logic             locked
);

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int LW = $clog2(LOCK_WINDOWS + 1);
    localparam int C_MAXI = (1 << CNT_W) - 1;

    localparam logic [GW-1:0]    G_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX  = '1;
    localparam logic [CNT_W-1:0] C_LO   = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] C_HI   = CNT_W'(EXP_MAX);
    localparam logic [LW-1:0]    L_TGT  = LW'(LOCK_WINDOWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             s1, s2, hist;
    logic             edge_det;
    logic [1:0]       arm_cnt;
    logic [GW-1:0]    gate;
    logic [CNT_W-1:0] ecnt, fin_cnt;
    logic             ovf, fin_ovf;
    logic [LW-1:0]    good;
    logic             run, close;
    logic             lo_ok, hi_ok, fin_ok;

    // Two-flop synchronizer plus one history flop for rise detection
    always_ff @(posedge ck_in) begin
        if (sys_rst_i) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
        end else begin
            s1   <= sig_in;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign edge_det = s2 & ~hist;

    always_ff @(posedge ck_in) begin
        if (sys_rst_i) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (en) state_nxt = ARM;
            ARM:     if (arm_cnt == 2'd2) state_nxt = COUNT;
            COUNT:   state_nxt = COUNT;
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    always_comb begin
        run    = (state == COUNT) && en;
        close  = run && (gate == G_LAST);
        locked = (good == L_TGT);
    end

    // Saturating edge count including the edge seen this cycle
    always_comb begin
        fin_cnt = ecnt;
        fin_ovf = ovf;
        if (edge_det) begin
            if (ecnt == C_MAX) fin_ovf = 1'b1;
            else               fin_cnt = ecnt + CNT_W'(1);
        end
    end

    // Band limits that span the whole counter range are always satisfied
    if (EXP_MIN <= 0) begin : g_lo
        assign lo_ok = 1'b1;
    end else begin : g_lo
        assign lo_ok = (fin_cnt >= C_LO);
    end

    if (EXP_MAX >= C_MAXI) begin : g_hi
        assign hi_ok = 1'b1;
    end else begin : g_hi
        assign hi_ok = (fin_cnt <= C_HI);
    end

    assign fin_ok = lo_ok && hi_ok && !fin_ovf;

    always_ff @(posedge ck_in) begin
        if (sys_rst_i) begin
            arm_cnt     <= '0;
            gate        <= '0;
            ecnt        <= '0;
            ovf         <= 1'b0;
            good        <= '0;
            count       <= '0;
            count_valid <= 1'b0;
            in_range    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            count_valid <= close;
            arm_cnt     <= (state == ARM) ? arm_cnt + 2'd1 : 2'd0;
            if (!run) begin
                gate <= '0;
                ecnt <= '0;
                ovf  <= 1'b0;
            end else if (close) begin
                gate     <= '0;
                ecnt     <= '0;
                ovf      <= 1'b0;
                count    <= fin_cnt;
                overflow <= fin_ovf;
                in_range <= fin_ok;
                if (!fin_ok)            good <= '0;
                else if (good != L_TGT) good <= good + LW'(1);
            end else begin
                gate <= gate + GW'(1);
                ecnt <= fin_cnt;
                ovf  <= fin_ovf;
            end
            if (!en) good <= '0;
        end
    end

endmodule

// File: tb/tb_ck_freq_mon.sv
// Bench for ck_freq_mon: two widths share stimulus and are checked
// every cycle against a window-level model, plus directed spot checks.
module tb_ck_freq_mon;

    logic       ck_in = 1'b0;
    logic       sys_rst_i = 1'b1;
    logic       sig_in = 1'b0;
    logic       en = 1'b1;

    logic [3:0] cnt_a;
    logic       vld_a, rng_a, ovf_a, lck_a;
    logic [1:0] cnt_b;
    logic       vld_b, rng_b, ovf_b, lck_b;

    int nvec = 0;
    int nerr = 0;

    always #5 ck_in = ~ck_in;

    ck_freq_mon #(
        .GATE_CYCLES(16), .CNT_W(4), .EXP_MIN(3),
        .EXP_MAX(5), .LOCK_WINDOWS(2)
    ) u_a (
        .ck_in(ck_in), .sys_rst_i(sys_rst_i), .sig_in(sig_in),
        .en(en), .count(cnt_a), .count_valid(vld_a),
        .in_range(rng_a), .overflow(ovf_a), .locked(lck_a)
    );

    ck_freq_mon #(
        .GATE_CYCLES(16), .CNT_W(2), .EXP_MIN(3),
        .EXP_MAX(5), .LOCK_WINDOWS(2)
    ) u_b (
        .ck_in(ck_in), .sys_rst_i(sys_rst_i), .sig_in(sig_in),
        .en(en), .count(cnt_b), .count_valid(vld_b),
        .in_range(rng_b), .overflow(ovf_b), .locked(lck_b)
    );

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: a = cycles since en was seen high from idle; windows
    // occupy a = 4+16w .. 19+16w; a rise sampled at edge k is
    // counted at edge k+2.
    int a = -1;
    int raw = 0;
    bit v1, v2, v3;
    bit started = 0;
    int e_cnt[2], e_rng[2], e_ovf[2], e_val[2], streak[2];

    always @(posedge ck_in) begin
        bit det;
        started = 1;
        if (sys_rst_i) begin
            v1 = 0; v2 = 0; v3 = 0;
            a = -1;
            raw = 0;
            for (int i = 0; i < 2; i++) begin
                e_cnt[i] = 0; e_rng[i] = 0; e_ovf[i] = 0;
                e_val[i] = 0; streak[i] = 0;
            end
        end else begin
            det = v2 && !v3;
            v3 = v2; v2 = v1; v1 = sig_in;
            e_val[0] = 0;
            e_val[1] = 0;
            if (!en) begin
                a = -1;
                streak[0] = 0;
                streak[1] = 0;
            end else begin
                a++;
                if (a >= 4) begin
                    if ((a - 4) % 16 == 0) raw = 0;
                    raw += int'(det);
                    if ((a - 4) % 16 == 15) begin
                        for (int i = 0; i < 2; i++) begin
                            int maxv;
                            maxv = (i == 0) ? 15 : 3;
                            e_ovf[i] = (raw > maxv);
                            e_cnt[i] = e_ovf[i] ? maxv : raw;
                            e_rng[i] = !e_ovf[i] && raw >= 3 && raw <= 5;
                            if (e_rng[i]) streak[i] = (streak[i] < 2) ? streak[i] + 1 : 2;
                            else          streak[i] = 0;
                            e_val[i] = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge ck_in) begin
        if (started) begin
            chk("a_count", int'(cnt_a), e_cnt[0]);
            chk("a_valid", int'(vld_a), e_val[0]);
            chk("a_range", int'(rng_a), e_rng[0]);
            chk("a_ovf",   int'(ovf_a), e_ovf[0]);
            chk("a_lock",  int'(lck_a), int'(streak[0] == 2));
            chk("b_count", int'(cnt_b), e_cnt[1]);
            chk("b_valid", int'(vld_b), e_val[1]);
            chk("b_range", int'(rng_b), e_rng[1]);
            chk("b_ovf",   int'(ovf_b), e_ovf[1]);
            chk("b_lock",  int'(lck_b), int'(streak[1] == 2));
        end
    end

    int per = 2;
    int ph = 0;

    task automatic tick();
        @(negedge ck_in);
        if (per != 0) begin
            sig_in = (ph < per / 2);
            ph = (ph + 1) % per;
        end
    endtask

    task automatic set_per(input int p);
        per = p;
        ph = 0;
    endtask

    task automatic wait_vld();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!vld_a && n < 40);
        chk("vld_wait", int'(vld_a), 1);
    endtask

    task automatic latency();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!vld_a && n < 40);
        chk("first_pulse_cycle", n, 20);
    endtask

    initial begin
        int seen;
        int pl [7];
        pl = '{0, 3, 4, 5, 6, 8, 10};

        sys_rst_i = 1'b1;
        en = 1'b1;
        set_per(2);
        repeat (3) tick();
        sys_rst_i = 1'b0;
        set_per(4);
        latency();

        wait_vld();
        chk("nom_count", int'(cnt_a), 4);
        chk("nom_range", int'(rng_a), 1);
        chk("nom_lock", int'(lck_a), 1);
        chk("nom_b_count", int'(cnt_b), 3);
        chk("nom_b_ovf", int'(ovf_b), 1);
        chk("nom_b_lock", int'(lck_b), 0);
        repeat (2) wait_vld();
        chk("nom_lock_hold", int'(lck_a), 1);

        set_per(8);
        repeat (3) wait_vld();
        chk("slow_count", int'(cnt_a), 2);
        chk("slow_range", int'(rng_a), 0);
        chk("slow_lock", int'(lck_a), 0);

        set_per(4);
        repeat (3) wait_vld();
        chk("relock", int'(lck_a), 1);

        set_per(2);
        repeat (2) wait_vld();
        chk("fast_count", int'(cnt_a), 8);
        chk("fast_range", int'(rng_a), 0);
        chk("fast_b_count", int'(cnt_b), 3);
        chk("fast_b_ovf", int'(ovf_b), 1);
        chk("fast_b_range", int'(rng_b), 0);

        set_per(4);
        repeat (3) wait_vld();
        chk("pre_drop_lock", int'(lck_a), 1);
        repeat (10) tick();
        en = 1'b0;
        tick();
        chk("drop_lock", int'(lck_a), 0);
        chk("drop_count", int'(cnt_a), 4);
        seen = 0;
        repeat (20) begin
            tick();
            seen |= int'(vld_a);
        end
        chk("drop_no_pulse", seen, 0);
        en = 1'b1;
        latency();
        chk("reen_count", int'(cnt_a), 4);

        set_per(0);
        sig_in = 1'b0;
        repeat (2) wait_vld();
        repeat (13) tick();
        sig_in = 1'b1;
        wait_vld();
        chk("bound_count", int'(cnt_a), 1);
        chk("bound_b_count", int'(cnt_b), 1);
        wait_vld();
        chk("bound_next", int'(cnt_a), 0);

        for (int s = 0; s < 25; s++) begin
            int r;
            r = $urandom % 10;
            set_per(pl[$urandom % 7]);
            if (per == 0) sig_in = 1'($urandom % 2);
            sys_rst_i = (r == 0);
            en = !(r == 1 || r == 2);
            repeat (2) tick();
            sys_rst_i = 1'b0;
            en = 1'b1;
            repeat ($urandom_range(10, 60)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
